// File: rtl/lcd_refresh_ctrl.sv
// HD44780 refresh controller: power-up delay, init sequence, then continuous
// two-line frame refresh from a 32x8 character RAM.
module lcd_refresh_ctrl #(
    parameter int unsigned EN_CYCLES = 25,
    parameter int unsigned CMD_WAIT  = 2500,
    parameter int unsigned CLR_WAIT  = 100000,
    parameter int unsigned PWR_WAIT  = 1000000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       refresh_en,
    output logic [4:0] raddr,
    input  logic [7:0] rdata,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic       lcd_on,
    output logic       frame_done,
    output logic       init_done
);

    localparam int unsigned MAX_A = (PWR_WAIT > CLR_WAIT) ? PWR_WAIT : CLR_WAIT;
    localparam int unsigned MAX_B = (CMD_WAIT > EN_CYCLES) ? CMD_WAIT : EN_CYCLES;
    localparam int unsigned MAX_W = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CW    = $clog2(MAX_W + 1);

    localparam logic [CW-1:0] EN_LAST  = CW'(EN_CYCLES - 1);
    localparam logic [CW-1:0] CMD_LAST = CW'(CMD_WAIT - 1);
    localparam logic [CW-1:0] CLR_LAST = CW'(CLR_WAIT - 1);
    localparam logic [CW-1:0] PWR_LAST = CW'(PWR_WAIT - 1);
    // raddr leads by one cycle so the next character is on rdata at its SETUP edge
    localparam logic [CW-1:0] ADV_AT    = (CMD_WAIT >= 2) ? CW'(CMD_WAIT - 2) : '0;
    localparam bit            ADV_IN_EN = (CMD_WAIT < 2);

    typedef enum logic [2:0] {
        S_PWRUP, S_INIT, S_IDLE, S_L1CMD, S_L1CHR, S_L2CMD, S_L2CHR, S_FDONE
    } state_t;

    typedef enum logic [1:0] {PH_SETUP, PH_EN, PH_HOLD} phase_t;

    state_t        state_q, state_d;
    phase_t        phase_q, phase_d;
    logic [CW-1:0] cnt_q, cnt_d, hold_last;
    logic [1:0]    idx_q, idx_d;
    logic [4:0]    raddr_d;
    logic [7:0]    data_d, start_data;
    logic          rs_d, start_rs, start, init_d, en_d, fd_d;
    logic          in_xfer, xfer_end, adv;

    assign lcd_rw = 1'b0;
    assign lcd_on = reset_n;

    assign in_xfer   = state_q inside {S_INIT, S_L1CMD, S_L1CHR, S_L2CMD, S_L2CHR};
    assign hold_last = (!lcd_rs && lcd_data == 8'h01) ? CLR_LAST : CMD_LAST;

    function automatic logic [7:0] init_cmd(input logic [1:0] i);
        case (i)
            2'd0:    init_cmd = 8'h38;
            2'd1:    init_cmd = 8'h0C;
            2'd2:    init_cmd = 8'h01;
            default: init_cmd = 8'h06;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_PWRUP;
            phase_q    <= PH_SETUP;
            cnt_q      <= '0;
            idx_q      <= '0;
            raddr      <= '0;
            lcd_data   <= '0;
            lcd_rs     <= 1'b0;
            lcd_en     <= 1'b0;
            frame_done <= 1'b0;
            init_done  <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            raddr      <= raddr_d;
            lcd_data   <= data_d;
            lcd_rs     <= rs_d;
            lcd_en     <= en_d;
            frame_done <= fd_d;
            init_done  <= init_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        raddr_d    = raddr;
        data_d     = lcd_data;
        rs_d       = lcd_rs;
        init_d     = init_done;
        start      = 1'b0;
        start_data = 8'h00;
        start_rs   = 1'b0;
        xfer_end   = 1'b0;
        adv        = 1'b0;

        // SETUP -> EN -> HOLD sequencing shared by every write
        if (in_xfer) begin
            case (phase_q)
                PH_SETUP: begin
                    phase_d = PH_EN;
                    cnt_d   = '0;
                end
                PH_EN: begin
                    if (cnt_q == EN_LAST) begin
                        phase_d = PH_HOLD;
                        cnt_d   = '0;
                        adv     = ADV_IN_EN;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                PH_HOLD: begin
                    adv = !ADV_IN_EN && (cnt_q == ADV_AT);
                    if (cnt_q == hold_last) xfer_end = 1'b1;
                    else                    cnt_d = cnt_q + CW'(1);
                end
                default: phase_d = PH_SETUP;
            endcase
        end

        case (state_q)
            S_PWRUP: begin
                if (cnt_q == PWR_LAST) begin
                    state_d    = S_INIT;
                    idx_d      = 2'd0;
                    start      = 1'b1;
                    start_data = init_cmd(2'd0);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_INIT: begin
                if (xfer_end) begin
                    if (idx_q == 2'd3) begin
                        state_d = S_IDLE;
                        init_d  = 1'b1;
                    end else begin
                        idx_d      = idx_q + 2'd1;
                        start      = 1'b1;
                        start_data = init_cmd(idx_q + 2'd1);
                    end
                end
            end
            S_IDLE, S_FDONE: begin
                if (refresh_en) begin
                    state_d    = S_L1CMD;
                    start      = 1'b1;
                    start_data = 8'h80;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_L1CMD, S_L2CMD: begin
                if (xfer_end) begin
                    state_d    = (state_q == S_L1CMD) ? S_L1CHR : S_L2CHR;
                    start      = 1'b1;
                    start_data = rdata;
                    start_rs   = 1'b1;
                end
            end
            S_L1CHR: begin
                if (adv) raddr_d = raddr + 5'd1;
                if (xfer_end) begin
                    start = 1'b1;
                    if (raddr == 5'd16) begin
                        state_d    = S_L2CMD;
                        start_data = 8'hC0;
                    end else begin
                        start_data = rdata;
                        start_rs   = 1'b1;
                    end
                end
            end
            S_L2CHR: begin
                if (adv) raddr_d = raddr + 5'd1;
                if (xfer_end) begin
                    if (raddr == 5'd0) begin
                        state_d = S_FDONE;
                    end else begin
                        start      = 1'b1;
                        start_data = rdata;
                        start_rs   = 1'b1;
                    end
                end
            end
            default: state_d = S_PWRUP;
        endcase

        if (start) begin
            phase_d = PH_SETUP;
            cnt_d   = '0;
            data_d  = start_data;
            rs_d    = start_rs;
        end

        en_d = (state_d inside {S_INIT, S_L1CMD, S_L1CHR, S_L2CMD, S_L2CHR})
               && (phase_d == PH_EN);
        fd_d = (state_d == S_FDONE);
    end

endmodule

// File: tb/tb_lcd_refresh_ctrl.sv
// Scoreboard bench for lcd_refresh_ctrl: init sequence, frame content/timing,
// RAM update between frames, refresh stop and mid-transaction reset.
module tb_lcd_refresh_ctrl;

    localparam int unsigned EN  = 2;
    localparam int unsigned CMD = 3;
    localparam int unsigned CLR = 6;
    localparam int unsigned PWR = 10;
    localparam int unsigned TXN = 1 + EN + CMD;

    typedef struct {
        logic        rs;
        logic [7:0]  data;
        int unsigned rise;
        int unsigned width;
    } txn_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       refresh_en;
    logic [4:0] raddr;
    logic [7:0] rdata;
    logic [7:0] lcd_data;
    logic       lcd_rs, lcd_rw, lcd_en, lcd_on, frame_done, init_done;

    logic [7:0]  ram [32];
    int unsigned cyc;
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned init_rise;
    int unsigned frame_base;
    txn_t        obs_q[$];
    txn_t        exp_q[$];
    int unsigned fd_q[$];
    int unsigned fd_exp_q[$];
    txn_t        cur;
    logic        en_prev, init_prev;

    always #10 clk = ~clk;

    assign rdata = ram[raddr];

    lcd_refresh_ctrl #(
        .EN_CYCLES(EN), .CMD_WAIT(CMD), .CLR_WAIT(CLR), .PWR_WAIT(PWR)
    ) dut (
        .clk(clk), .reset_n(reset_n), .refresh_en(refresh_en),
        .raddr(raddr), .rdata(rdata), .lcd_data(lcd_data), .lcd_rs(lcd_rs),
        .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_on(lcd_on),
        .frame_done(frame_done), .init_done(init_done)
    );

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    // Bus monitor: one record per enable strobe, captured at its falling edge
    always @(negedge clk) begin
        if (!reset_n) begin
            en_prev   = 1'b0;
            init_prev = 1'b0;
        end else begin
            if (lcd_en && !en_prev) begin
                cur.rs    = lcd_rs;
                cur.data  = lcd_data;
                cur.rise  = cyc;
                cur.width = 0;
            end
            if (lcd_en) cur.width++;
            if (!lcd_en && en_prev) obs_q.push_back(cur);
            if (frame_done) fd_q.push_back(cyc);
            if (init_done && !init_prev) init_rise = cyc;
            en_prev   = lcd_en;
            init_prev = init_done;
        end
    end

    task automatic push_frame(input int unsigned start);
        txn_t e;
        for (int k = 0; k < 34; k++) begin
            e.rise  = start + TXN * k;
            e.width = EN;
            if (k == 0)       begin e.rs = 1'b0; e.data = 8'h80;      end
            else if (k == 17) begin e.rs = 1'b0; e.data = 8'hC0;      end
            else if (k < 17)  begin e.rs = 1'b1; e.data = ram[k - 1]; end
            else              begin e.rs = 1'b1; e.data = ram[k - 2]; end
            exp_q.push_back(e);
        end
        fd_exp_q.push_back(start + TXN * 33 + EN + CMD);
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        refresh_en = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({lcd_en, lcd_rs, lcd_rw, frame_done, init_done, lcd_on, lcd_data, raddr} !== 19'd0) begin
            n_err++;
            $display("FAIL reset_outputs: en=%b rs=%b rw=%b fd=%b id=%b on=%b data=%02h raddr=%0d, want all 0",
                     lcd_en, lcd_rs, lcd_rw, frame_done, init_done, lcd_on, lcd_data, raddr);
        end
        init_rise = 0;
        reset_n   = 1'b1;
        #1;
        n_cmp++;
        if (lcd_on !== 1'b1) begin
            n_err++;
            $display("FAIL lcd_on_release: got %b want 1", lcd_on);
        end
    endtask

    task automatic test_init();
        txn_t        e, o;
        int unsigned r = 11;
        int unsigned w;
        for (int k = 0; k < 4; k++) begin
            e.rs    = 1'b0;
            e.data  = (k == 0) ? 8'h38 : (k == 1) ? 8'h0C : (k == 2) ? 8'h01 : 8'h06;
            e.rise  = r;
            e.width = EN;
            exp_q.push_back(e);
            r += 1 + EN + ((k == 2) ? CLR : CMD);
        end
        for (int k = 0; k < 4; k++) begin
            w = 0;
            while (obs_q.size() == 0 && w < 400) begin @(negedge clk); w++; end
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_err++;
                $display("FAIL init_cmd%0d: no strobe, want data=%02h rise=%0d", k, e.data, e.rise);
            end else begin
                o = obs_q.pop_front();
                if (o.rs !== e.rs || o.data !== e.data || o.rise != e.rise || o.width != e.width) begin
                    n_err++;
                    $display("FAIL init_cmd%0d: got rs=%b data=%02h rise=%0d en=%0d want rs=%b data=%02h rise=%0d en=%0d",
                             k, o.rs, o.data, o.rise, o.width, e.rs, e.data, e.rise, e.width);
                end
            end
        end
        w = 0;
        while (init_rise == 0 && w < 100) begin @(negedge clk); w++; end
        n_cmp++;
        if (init_rise != r - 1) begin
            n_err++;
            $display("FAIL init_done_rise: got cycle %0d want %0d", init_rise, r - 1);
        end
    endtask

    task automatic test_frame();
        txn_t        e, o;
        int unsigned w, f;
        @(negedge clk);
        frame_base = cyc;
        refresh_en = 1'b1;
        push_frame(frame_base + 2);
        w = 0;
        while (raddr != 5'd10 && w < 400) begin @(negedge clk); w++; end
        ram[5] = "X";
        push_frame(frame_base + 2 + 34 * TXN + 1);
        for (int k = 0; k < 68; k++) begin
            w = 0;
            while (obs_q.size() == 0 && w < 400) begin @(negedge clk); w++; end
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_err++;
                $display("FAIL frame_txn%0d: no strobe, want data=%02h rise=%0d", k, e.data, e.rise);
            end else begin
                o = obs_q.pop_front();
                if (o.rs !== e.rs || o.data !== e.data || o.rise != e.rise || o.width != e.width) begin
                    n_err++;
                    $display("FAIL frame_txn%0d: got rs=%b data=%02h rise=%0d en=%0d want rs=%b data=%02h rise=%0d en=%0d",
                             k, o.rs, o.data, o.rise, o.width, e.rs, e.data, e.rise, e.width);
                end
            end
        end
        for (int k = 0; k < 2; k++) begin
            w = 0;
            while (fd_q.size() == 0 && w < 400) begin @(negedge clk); w++; end
            f = fd_exp_q.pop_front();
            n_cmp++;
            if (fd_q.size() == 0) begin
                n_err++;
                $display("FAIL frame_done%0d: no pulse, want cycle %0d", k, f);
            end else if (fd_q[0] != f) begin
                n_err++;
                $display("FAIL frame_done%0d: got cycle %0d want %0d", k, fd_q[0], f);
                void'(fd_q.pop_front());
            end else begin
                void'(fd_q.pop_front());
            end
        end
    endtask

    task automatic test_refresh_stop();
        txn_t        e, o;
        int unsigned w, f, bad;
        push_frame(frame_base + 2 + 2 * (34 * TXN + 1));
        w = 0;
        while (raddr != 5'd7 && w < 400) begin @(negedge clk); w++; end
        refresh_en = 1'b0;
        for (int k = 0; k < 34; k++) begin
            w = 0;
            while (obs_q.size() == 0 && w < 400) begin @(negedge clk); w++; end
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_err++;
                $display("FAIL stop_txn%0d: no strobe, want data=%02h rise=%0d", k, e.data, e.rise);
            end else begin
                o = obs_q.pop_front();
                if (o.rs !== e.rs || o.data !== e.data || o.rise != e.rise || o.width != e.width) begin
                    n_err++;
                    $display("FAIL stop_txn%0d: got rs=%b data=%02h rise=%0d en=%0d want rs=%b data=%02h rise=%0d en=%0d",
                             k, o.rs, o.data, o.rise, o.width, e.rs, e.data, e.rise, e.width);
                end
            end
        end
        w = 0;
        while (fd_q.size() == 0 && w < 400) begin @(negedge clk); w++; end
        f = fd_exp_q.pop_front();
        n_cmp++;
        if (fd_q.size() == 0 || fd_q[0] != f) begin
            n_err++;
            $display("FAIL stop_frame_done: got %0d pulses (first %0d) want cycle %0d",
                     fd_q.size(), (fd_q.size() != 0) ? fd_q[0] : 0, f);
        end
        fd_q.delete();
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (lcd_en || frame_done) bad++;
        end
        n_cmp++;
        if (bad != 0 || obs_q.size() != 0) begin
            n_err++;
            $display("FAIL idle_quiet: got %0d active cycles, %0d strobes want 0", bad, obs_q.size());
        end
        n_cmp++;
        if (raddr !== 5'd0) begin
            n_err++;
            $display("FAIL idle_raddr: got %0d want 0", raddr);
        end
    endtask

    task automatic test_reset_mid_en();
        int unsigned w;
        @(negedge clk);
        refresh_en = 1'b1;
        w = 0;
        while (!(lcd_en && raddr == 5'd20) && w < 400) begin @(negedge clk); w++; end
        n_cmp++;
        if (!(lcd_en && raddr == 5'd20)) begin
            n_err++;
            $display("FAIL reach_char20: got en=%b raddr=%0d want en=1 raddr=20", lcd_en, raddr);
        end
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({lcd_en, lcd_rs, init_done, lcd_on, lcd_data, raddr} !== 17'd0) begin
            n_err++;
            $display("FAIL reset_mid_en: en=%b rs=%b id=%b on=%b data=%02h raddr=%0d, want all 0",
                     lcd_en, lcd_rs, init_done, lcd_on, lcd_data, raddr);
        end
        refresh_en = 1'b0;
        repeat (3) @(negedge clk);
        obs_q.delete();
        fd_q.delete();
        init_rise = 0;
        reset_n   = 1'b1;
        test_init();
    endtask

    initial begin
        string l1 = "LCD";
        string l2 = "Demonstration";
        for (int i = 0; i < 16; i++) begin
            ram[i]      = (i < l1.len()) ? l1[i] : 8'h20;
            ram[16 + i] = (i < l2.len()) ? l2[i] : 8'h20;
        end
        test_reset();
        test_init();
        test_frame();
        test_refresh_stop();
        test_reset_mid_en();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lcd_refresh_ctrl.md
LCD_REFRESH_CTRL -- requirements
Module: lcd_refresh_ctrl

Interface
REQ-001 SHALL have parameter EN_CYCLES, default 25, meaning the lcd_en high width in clk cycles (500 ns at 50 MHz).
REQ-002 SHALL have parameter CMD_WAIT, default 2500, meaning the post-EN wait in cycles after a normal command or character write (50 us).
REQ-003 SHALL have parameter CLR_WAIT, default 100000, meaning the post-EN wait in cycles after the clear command 0x01 (2 ms).
REQ-004 SHALL have parameter PWR_WAIT, default 1000000, meaning the power-up delay in cycles before the first command (20 ms).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port refresh_en, input, 1 bit: when high, refresh frames run continuously; when low, the block pauses after the current frame.
REQ-008 SHALL have port raddr, output, 5 bits: read address into the 32x8 display character RAM.
REQ-009 SHALL have port rdata, input, 8 bits: character at raddr, valid combinationally in the same cycle.
REQ-010 SHALL have port lcd_data, output, 8 bits: HD44780 DB7..DB0.
REQ-011 SHALL have port lcd_rs, output, 1 bit: 0 selects a command, 1 selects data.
REQ-012 SHALL have port lcd_rw, output, 1 bit: constant 0 (write only).
REQ-013 SHALL have port lcd_en, output, 1 bit: the HD44780 enable strobe.
REQ-014 SHALL have port lcd_on, output, 1 bit: panel power, 1 whenever reset_n is high.
REQ-015 SHALL have port frame_done, output, 1 bit: one-cycle pulse after the last character of a frame completes.
REQ-016 SHALL have port init_done, output, 1 bit: level, high once the init sequence has completed.

Function
REQ-017 SHALL perform every LCD write as one transaction of three phases: SETUP for 1 cycle (lcd_data and lcd_rs updated, lcd_en=0); EN for EN_CYCLES cycles (lcd_en=1); HOLD for W cycles (lcd_en=0), where W=CLR_WAIT for command 0x01 and W=CMD_WAIT otherwise.
REQ-018 SHALL keep lcd_data and lcd_rs constant from SETUP through the end of HOLD, and SHALL change them only on the edge entering a SETUP.
REQ-019 SHALL run the states in this order: PWRUP (PWR_WAIT cycles, no strobes) -> INIT -> IDLE.
REQ-020 In INIT, SHALL issue the commands 0x38, 0x0C, 0x01, 0x06 in that order with lcd_rs=0, and SHALL set init_done on the edge ending the HOLD of 0x06.
REQ-021 In IDLE with refresh_en=1, SHALL move to L1CMD on the next edge; with refresh_en=0, SHALL remain in IDLE with lcd_en=0.
REQ-022 In L1CMD, SHALL write command 0x80, then go to L1CHR.
REQ-023 In L1CHR, SHALL write characters at raddr 0..15 with lcd_rs=1, then go to L2CMD.
REQ-024 In L2CMD, SHALL write command 0xC0, then go to L2CHR.
REQ-025 In L2CHR, SHALL write characters at raddr 16..31, then go to FDONE.
REQ-026 In FDONE, SHALL assert frame_done for exactly 1 cycle, then go to L1CMD if refresh_en=1, else to IDLE.
REQ-027 For a character write, SHALL capture lcd_data from rdata on the edge entering SETUP, with raddr already equal to the character index during the preceding cycle.
REQ-028 SHALL increment raddr by 1 on the edge ending each character HOLD, wrapping from 31 to 0 at frame end; the 5-bit wrap is natural.
REQ-029 SHALL sample refresh_en only in IDLE and FDONE; deasserting it mid-frame SHALL NOT truncate the frame.
REQ-030 SHALL ignore RAM content changes during a transaction; each character is sampled only at its SETUP.
REQ-031 SHALL make the total cycles per frame equal 34*(1+EN_CYCLES+CMD_WAIT)+1, with no idle gap between transactions.
REQ-032 SHALL hold all counters at widths sufficient for PWR_WAIT and SHALL NOT let them overflow.

Reset
REQ-033 On reset_n low, SHALL immediately force lcd_en=0, lcd_rs=0, lcd_rw=0, lcd_data=0x00, raddr=0, frame_done=0, init_done=0, and state PWRUP, independent of clk.
REQ-034 On reset_n low mid-transaction (including during EN), SHALL abort the transaction; after release, the full PWRUP and INIT sequence SHALL rerun.
REQ-035 While reset_n is low, SHALL drive lcd_on=0; it SHALL go to 1 combinationally on release.

Verification
REQ-036 With EN_CYCLES=2, CMD_WAIT=3, CLR_WAIT=6, PWR_WAIT=10, release reset -> first lcd_en rise at cycle 11, command bytes 0x38, 0x0C, 0x01, 0x06 with 3/3/6/3 HOLD cycles, init_done high after the 0x06 HOLD.
REQ-037 Preload the RAM with "LCD" followed by spaces, then "Demonstration" followed by spaces; set refresh_en=1 -> bus shows 0x80, 'L','C','D',0x20 x13, 0xC0, 'D','e',...,'n',0x20 x3, then a frame_done pulse; frame length 34*6+1 = 205 cycles.
REQ-038 Write RAM addr 5 = 'X' while raddr=10 -> the current frame is unchanged, and the next frame outputs 'X' at position 5.
REQ-039 Drop refresh_en at character 7 -> the frame completes through 31, frame_done pulses, the FSM enters IDLE, and lcd_en stays 0 for 100 cycles.
REQ-040 Assert reset_n low during the EN phase of character 20 -> lcd_en falls within the same cycle, raddr=0, and after release PWRUP and INIT repeat exactly as in REQ-036.
